mcycle_gen: RTL and testbench

MCYCLE_GEN -- requirements
Module: mcycle_gen

---
 rtl/mcycle_gen.sv | 163 ++++++++++++++++
 tb/tb_mcycle_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_gen.sv
// mcycle_gen: iterative multiply/divide unit, one operand bit per clock.
// Define MCYCLE_GEN_DIV_EN to include the restoring divider (ops 10/11).
module mcycle_gen #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Abort,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH:0]     r_hi;
  logic               r_neg_q;
  logic [WIDTH-1:0]   r_result1;
  logic [WIDTH-1:0]   r_result2;
  logic               r_divzero;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH:0]     w_next_hi;
  logic [WIDTH-1:0]   w_next_lo;
  logic [WIDTH-1:0]   w_fin1;
  logic [WIDTH-1:0]   w_fin2;
  logic               w_fin_dz;

  // Both datapaths work on magnitudes; signs are reapplied on the final step.
  assign w_a_neg  = MCycleOp[0] & Operand1[WIDTH-1];
  assign w_b_neg  = MCycleOp[0] & Operand2[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -Operand1 : Operand1;
  assign w_b_mag  = w_b_neg ? -Operand2 : Operand2;
  assign w_accept = Start && (r_state != S_COMPUTE);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Shift-add: {w_add, r_lo[W-1:1]} is the shifted {hi, lo} pair after this step.
  assign w_add    = r_lo[0] ? (r_hi + {1'b0, r_mcand}) : r_hi;
  assign w_prod   = {w_add, r_lo[WIDTH-1:1]};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;

`ifdef MCYCLE_GEN_DIV_EN
  logic             r_is_div;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH:0]   w_div_hi;
  logic [WIDTH-1:0] w_quo;

  // Restoring divide: r_hi holds the partial remainder, r_lo shifts dividend out / quotient in.
  assign w_shift   = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_mcand};
  assign w_ge      = ~w_diff[WIDTH+1];
  assign w_div_hi  = w_ge ? w_diff[WIDTH:0] : w_shift;
  assign w_quo     = {r_lo[WIDTH-2:0], w_ge};

  assign w_next_hi = r_is_div ? w_div_hi : {1'b0, w_add[WIDTH:1]};
  assign w_next_lo = r_is_div ? w_quo : {w_add[0], r_lo[WIDTH-1:1]};
  assign w_fin1    = !r_is_div ? w_prod_s[WIDTH-1:0] :
                     r_dz      ? '1 :
                     r_neg_q   ? -w_quo : w_quo;
  assign w_fin2    = !r_is_div ? w_prod_s[2*WIDTH-1:WIDTH] :
                     r_dz      ? r_op1 :
                     r_neg_r   ? -w_div_hi[WIDTH-1:0] : w_div_hi[WIDTH-1:0];
  assign w_fin_dz  = r_is_div & r_dz;
`else
  assign w_next_hi = {1'b0, w_add[WIDTH:1]};
  assign w_next_lo = {w_add[0], r_lo[WIDTH-1:1]};
  assign w_fin1    = w_prod_s[WIDTH-1:0];
  assign w_fin2    = w_prod_s[2*WIDTH-1:WIDTH];
  assign w_fin_dz  = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_neg_q   <= 1'b0;
      r_result1 <= '0;
      r_result2 <= '0;
      r_divzero <= 1'b0;
`ifdef MCYCLE_GEN_DIV_EN
      r_is_div  <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_op1     <= '0;
`endif
    end else if (Abort) begin
      r_state <= S_IDLE;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_hi    <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
`ifdef MCYCLE_GEN_DIV_EN
      r_is_div <= MCycleOp[1];
      r_neg_r  <= w_a_neg;
      r_dz     <= (Operand2 == '0);
      r_op1    <= Operand1;
      r_mcand  <= MCycleOp[1] ? w_b_mag : w_a_mag;
      r_lo     <= MCycleOp[1] ? w_a_mag : w_b_mag;
      r_state  <= S_COMPUTE;
`else
      r_mcand <= w_a_mag;
      r_lo    <= w_b_mag;
      // Without a divider, division requests complete immediately with zero results.
      if (MCycleOp[1]) begin
        r_state   <= S_DONE;
        r_result1 <= '0;
        r_result2 <= '0;
        r_divzero <= 1'b0;
      end else begin
        r_state <= S_COMPUTE;
      end
`endif
    end else if (r_state == S_COMPUTE) begin
      r_hi  <= w_next_hi;
      r_lo  <= w_next_lo;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_state   <= S_DONE;
        r_result1 <= w_fin1;
        r_result2 <= w_fin2;
        r_divzero <= w_fin_dz;
      end
    end else begin
      r_state <= S_IDLE;
    end
  end

  assign Busy    = (r_state == S_COMPUTE);
  assign Done    = (r_state == S_DONE);
  assign Result1 = r_result1;
  assign Result2 = r_result2;
  assign DivZero = r_divzero;

endmodule

// File: tb/tb_mcycle_gen.sv
// Directed bench for mcycle_gen: 32-bit vector table plus abort/back-to-back/reset
// sequences, and an 8-bit instance for the narrow MIN/-1 corner.
module tb_mcycle_gen;

`ifdef MCYCLE_GEN_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [1:0]  op;
  logic [31:0] a, b, r1, r2;
  logic        busy, done, dz;

  logic        start8, abort8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, r1_8, r2_8;
  logic        busy8, done8, dz8;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mcycle_gen #(.WIDTH(32)) u_dut (
    .CLK(clk), .Reset_n(rst_n), .Start(start), .Abort(abort), .MCycleOp(op),
    .Operand1(a), .Operand2(b), .Result1(r1), .Result2(r2),
    .Busy(busy), .Done(done), .DivZero(dz)
  );

  mcycle_gen #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .Reset_n(rst_n), .Start(start8), .Abort(abort8), .MCycleOp(op8),
    .Operand1(a8), .Operand2(b8), .Result1(r1_8), .Result2(r2_8),
    .Busy(busy8), .Done(done8), .DivZero(dz8)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        edz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one 32-bit op; returns the cycle Done was seen (-1 on timeout) and Busy cycle count.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int dc, output int bc);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = $urandom;
    dc = -1; bc = 0;
    for (int n = 1; n <= 100; n++) begin
      if (busy) bc++;
      if (done) begin
        dc = n;
        break;
      end
      if (n == 5) start = 1'b1;
      if (n == 6) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int dc);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dc = -1;
    for (int n = 1; n <= 50; n++) begin
      if (done8) begin
        dc = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int dc, bc, exp_dc, exp_bc, cnt;
    logic [31:0] e1, e2, prev1, prev2;
    logic edz;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0};
    vecs[3]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0};
    vecs[4]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[5]  = '{2'b00, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};
    vecs[6]  = '{2'b01, 32'h80000000, 32'h00000001, 32'h80000000, 32'hFFFFFFFF, 1'b0};
    vecs[7]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{2'b10, 32'd100,      32'd0,        32'hFFFFFFFF, 32'd100,      1'b1};
    vecs[9]  = '{2'b10, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    vecs[10] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[11] = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0};
    vecs[12] = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0};
    vecs[13] = '{2'b11, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b1};

    rst_n = 1'b0; start = 1'b1; abort = 1'b0; op = 2'b00; a = 32'd3; b = 32'd4;
    start8 = 1'b0; abort8 = 1'b0; op8 = 2'b00; a8 = 8'd0; b8 = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dz", 64'(dz), 64'd0);
    check("reset_r1", 64'(r1), 64'd0);
    check("reset_r2", 64'(r2), 64'd0);
    start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run32(vecs[i].op, vecs[i].a, vecs[i].b, dc, bc);
      if (vecs[i].op[1] && !DIV_EN) begin
        e1 = '0; e2 = '0; edz = 1'b0; exp_dc = 1; exp_bc = 0;
      end else begin
        e1 = vecs[i].e1; e2 = vecs[i].e2; edz = vecs[i].edz; exp_dc = 33; exp_bc = 32;
      end
      $display("vec%0d op=%b %h,%h -> r2=%h r1=%h dz=%b done_cycle=%0d", i, vecs[i].op,
               vecs[i].a, vecs[i].b, r2, r1, dz, dc);
      check($sformatf("vec%0d_done_cycle", i), 64'(dc), 64'(exp_dc));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(exp_bc));
      check($sformatf("vec%0d_r1", i), 64'(r1), 64'(e1));
      check($sformatf("vec%0d_r2", i), 64'(r2), 64'(e2));
      check($sformatf("vec%0d_dz", i), 64'(dz), 64'(edz));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      check($sformatf("vec%0d_r1_hold", i), 64'(r1), 64'(e1));
    end

    // Abort on cycle 10 of COMPUTE: no Done, results keep the previous values.
    prev1 = r1; prev2 = r2;
    @(negedge clk);
    op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_after", 64'(busy), 64'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    $display("abort mid-compute -> r2=%h r1=%h", r2, r1);
    check("abort_no_done", 64'(cnt), 64'd0);
    check("abort_r1", 64'(r1), 64'(prev1));
    check("abort_r2", 64'(r2), 64'(prev2));

    // Abort together with Start: nothing accepted.
    @(negedge clk);
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'd0);
    check("abort_start_done", 64'(done), 64'd0);
    $display("abort+start -> busy=%b done=%b", busy, done);

    // Start held high through DONE: second op starts with no idle cycle.
    @(negedge clk);
    op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
    @(negedge clk);
    a = 32'd4; b = 32'd5;
    dc = -1;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        dc = n;
        break;
      end
      @(negedge clk);
    end
    check("b2b_first_cycle", 64'(dc), 64'd33);
    check("b2b_first_r1", 64'(r1), 64'd6);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_bubble", 64'(busy), 64'd1);
    dc = -1;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        dc = n;
        break;
      end
      @(negedge clk);
    end
    $display("back-to-back second -> r2=%h r1=%h gap=%0d", r2, r1, dc);
    check("b2b_gap", 64'(dc), 64'd33);
    check("b2b_second_r1", 64'(r1), 64'd20);
    check("b2b_second_r2", 64'(r2), 64'd0);

    // Reset asserted mid-COMPUTE clears everything without waiting for an edge.
    @(negedge clk);
    op = 2'b00; a = 32'hFFFFFFFF; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-compute -> busy=%b r1=%h r2=%h", busy, r1, r2);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_r1", 64'(r1), 64'd0);
    check("rst_mid_r2", 64'(r2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run32(2'b01, 32'hFFFFFFFD, 32'd7, dc, bc);
    $display("after reset op=01 -> r2=%h r1=%h done_cycle=%0d", r2, r1, dc);
    check("post_rst_cycle", 64'(dc), 64'd33);
    check("post_rst_prod", {r2, r1}, 64'hFFFFFFFF_FFFFFFEB);

    // Narrow build corners.
    run8(2'b11, 8'h80, 8'hFF, dc);
    $display("w8 op=11 80/ff -> r1=%h r2=%h dz=%b done_cycle=%0d", r1_8, r2_8, dz8, dc);
    check("w8_div_cycle", 64'(dc), DIV_EN ? 64'd9 : 64'd1);
    check("w8_div_r1", 64'(r1_8), DIV_EN ? 64'h80 : 64'h00);
    check("w8_div_r2", 64'(r2_8), 64'h00);
    check("w8_div_dz", 64'(dz8), 64'd0);
    run8(2'b01, 8'h80, 8'h80, dc);
    $display("w8 op=01 80*80 -> r2=%h r1=%h done_cycle=%0d", r2_8, r1_8, dc);
    check("w8_mul_cycle", 64'(dc), 64'd9);
    check("w8_mul_prod", 64'({r2_8, r1_8}), 64'h4000);
    run8(2'b00, 8'hFF, 8'hFF, dc);
    $display("w8 op=00 ff*ff -> r2=%h r1=%h done_cycle=%0d", r2_8, r1_8, dc);
    check("w8_umul_prod", 64'({r2_8, r1_8}), 64'hFE01);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
